request_unit: RTL and testbench

Fetch/memory request sequencer for the single-cycle datapath. It issues instruction fetches at the current PC and holds memory data requests until they complete. It produces the one-cycle `pcen` strobe that lets the program counter advance to its next value. It sits between the program counter/control decode and the instruction/data memory ports.

---
 rtl/request_unit_if.sv | 26 ++
 rtl/request_unit.sv | 100 ++++++++++
 tb/tb_request_unit.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/request_unit_if.sv
// Fetch/data request bundle between the request sequencer and the memory/decode side.
interface request_unit_if #(parameter int WORD_W = 32);
  logic              ihit;
  logic              dhit;
  logic [WORD_W-1:0] imemload;
  logic              dREN_req;
  logic              dWEN_req;
  logic              halt_req;
  logic              imemREN;
  logic              dmemREN;
  logic              dmemWEN;
  logic [WORD_W-1:0] instr;
  logic              pcen;
  logic              halt;
  logic [WORD_W-1:0] retired;

  modport master (
    input  ihit, dhit, imemload, dREN_req, dWEN_req, halt_req,
    output imemREN, dmemREN, dmemWEN, instr, pcen, halt, retired
  );

  modport slave (
    output ihit, dhit, imemload, dREN_req, dWEN_req, halt_req,
    input  imemREN, dmemREN, dmemWEN, instr, pcen, halt, retired
  );
endinterface

// File: rtl/request_unit.sv
// Fetch/memory request sequencer: issues instruction fetches, holds data requests
// until dhit, and strobes pcen once per retired instruction.
//
// state  | meaning
// IFETCH | fetching at PC; non-memory instructions retire on ihit
// DATA   | latched load/store outstanding; retires on dhit
// HALTED | HALT decoded; all requests off until reset
module request_unit #(
  parameter int WORD_W = 32
) (
  input  logic          CLK,
  input  logic          nRST,
  request_unit_if.master bus
);

  typedef enum logic [1:0] {IFETCH, DATA, HALTED} state_t;

  state_t            state, state_next;
  logic [WORD_W-1:0] ir;
  logic              is_store;
  logic [WORD_W-1:0] retired_q;
  logic              ir_load;
  logic              imem_ren;
  logic              dmem_ren;
  logic              dmem_wen;
  logic [WORD_W-1:0] instr_c;
  logic              pcen_c;
  logic              halt_c;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IFETCH;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    ir_load    = 1'b0;
    imem_ren   = 1'b0;
    dmem_ren   = 1'b0;
    dmem_wen   = 1'b0;
    instr_c    = ir;
    pcen_c     = 1'b0;
    halt_c     = 1'b0;
    case (state)
      IFETCH: begin
        imem_ren = 1'b1;
        instr_c  = bus.imemload;
        if (bus.ihit) begin
          // HALT wins over any load/store decode on the same word
          if (bus.halt_req) begin
            state_next = HALTED;
            ir_load    = 1'b1;
          end else if (bus.dREN_req || bus.dWEN_req) begin
            state_next = DATA;
            ir_load    = 1'b1;
          end else begin
            pcen_c = 1'b1;
          end
        end
      end
      DATA: begin
        dmem_wen = is_store;
        dmem_ren = ~is_store;
        if (bus.dhit) begin
          pcen_c     = 1'b1;
          state_next = IFETCH;
        end
      end
      HALTED: begin
        halt_c = 1'b1;
      end
      default: state_next = IFETCH;
    endcase
  end

  // The HALT word is latched too so instr keeps showing it while halted.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ir       <= '0;
      is_store <= 1'b0;
    end else if (ir_load) begin
      ir       <= bus.imemload;
      is_store <= bus.dWEN_req;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)       retired_q <= '0;
    else if (pcen_c) retired_q <= retired_q + 1'b1;
  end

  assign bus.imemREN = imem_ren;
  assign bus.dmemREN = dmem_ren;
  assign bus.dmemWEN = dmem_wen;
  assign bus.instr   = instr_c;
  assign bus.pcen    = pcen_c;
  assign bus.halt    = halt_c;
  assign bus.retired = retired_q;

endmodule

// File: tb/tb_request_unit.sv
// Randomized bench for request_unit against a cycle-level reference model,
// plus a 4-bit instance for the retire-counter wrap.
module tb_request_unit;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  logic nRST4 = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 CLK = ~CLK;

  request_unit_if #(.WORD_W(32)) bus ();
  request_unit_if #(.WORD_W(4))  bus4 ();

  request_unit #(.WORD_W(32)) dut  (.CLK(CLK), .nRST(nRST),  .bus(bus));
  request_unit #(.WORD_W(4))  dut4 (.CLK(CLK), .nRST(nRST4), .bus(bus4));

  // reference model: mode 0 = fetching, 1 = data pending, 2 = halted
  int          m_mode;
  logic [31:0] m_word;
  bit          m_store;
  logic [31:0] m_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_mode  = 0;
    m_word  = '0;
    m_store = 1'b0;
    m_cnt   = '0;
  endtask

  // one cycle: drive at negedge, check combinational outputs, advance model at posedge
  task automatic step(input bit i, input bit d, input logic [31:0] w,
                      input bit rr, input bit ww, input bit hh);
    bit e_pcen;
    @(negedge CLK);
    bus.ihit     = i;
    bus.dhit     = d;
    bus.imemload = w;
    bus.dREN_req = rr;
    bus.dWEN_req = ww;
    bus.halt_req = hh;
    #1;
    e_pcen = (m_mode == 0 && i && !hh && !rr && !ww) || (m_mode == 1 && d);
    chk("imemREN", 32'(bus.imemREN), 32'(m_mode == 0));
    chk("dmemREN", 32'(bus.dmemREN), 32'(m_mode == 1 && !m_store));
    chk("dmemWEN", 32'(bus.dmemWEN), 32'(m_mode == 1 && m_store));
    chk("instr",   bus.instr, (m_mode == 0) ? w : m_word);
    chk("pcen",    32'(bus.pcen), 32'(e_pcen));
    chk("halt",    32'(bus.halt), 32'(m_mode == 2));
    chk("retired", bus.retired, m_cnt);
    @(posedge CLK);
    if (e_pcen) m_cnt = m_cnt + 1;
    if (m_mode == 0 && i) begin
      if (hh) begin
        m_mode = 2;
        m_word = w;
      end else if (rr || ww) begin
        m_mode  = 1;
        m_word  = w;
        m_store = ww;
      end
    end else if (m_mode == 1 && d) begin
      m_mode = 0;
    end
  endtask

  // reset pulse between edges; release lands with dhit high, which must be ignored
  task automatic mid_reset();
    @(negedge CLK);
    bus.ihit     = 1'b0;
    bus.dhit     = 1'b0;
    bus.dREN_req = 1'b0;
    bus.dWEN_req = 1'b0;
    bus.halt_req = 1'b0;
    #2 nRST = 1'b0;
    #1;
    chk("rst_dmemREN", 32'(bus.dmemREN), 32'd0);
    chk("rst_dmemWEN", 32'(bus.dmemWEN), 32'd0);
    chk("rst_imemREN", 32'(bus.imemREN), 32'd1);
    chk("rst_halt",    32'(bus.halt),    32'd0);
    chk("rst_retired", bus.retired,      32'd0);
    m_reset();
    @(posedge CLK);
    @(negedge CLK);
    bus.dhit = 1'b1;
    #2 nRST = 1'b1;
    @(posedge CLK);
  endtask

  initial begin
    bit i, d, rr, ww, hh;
    bus.ihit = 0; bus.dhit = 0; bus.imemload = '0;
    bus.dREN_req = 0; bus.dWEN_req = 0; bus.halt_req = 0;
    bus4.ihit = 0; bus4.dhit = 0; bus4.imemload = '0;
    bus4.dREN_req = 0; bus4.dWEN_req = 0; bus4.halt_req = 0;
    m_reset();
    #1;
    chk("reset_imemREN", 32'(bus.imemREN), 32'd1);
    chk("reset_dmemREN", 32'(bus.dmemREN), 32'd0);
    chk("reset_dmemWEN", 32'(bus.dmemWEN), 32'd0);
    chk("reset_pcen",    32'(bus.pcen),    32'd0);
    chk("reset_halt",    32'(bus.halt),    32'd0);
    chk("reset_retired", bus.retired,      32'd0);
    chk("reset_instr",   bus.instr,        32'd0);
    @(negedge CLK);
    #2 nRST = 1'b1;

    // back-to-back non-memory retires
    repeat (3) step(1, 0, 32'h0, 0, 0, 0);
    step(0, 0, 32'h0, 0, 0, 0);
    chk("retired_after3", bus.retired, 32'd3);

    // load with three wait cycles
    step(1, 0, 32'h8C220004, 1, 0, 0);
    repeat (3) step(0, 0, $urandom, 0, 0, 0);
    step(0, 1, $urandom, 0, 0, 0);
    step(0, 0, 32'h0, 0, 0, 0);

    // store decoded as both read and write, with a spurious ihit while pending
    step(1, 0, 32'hAC430008, 1, 1, 0);
    step(1, 0, 32'h12345678, 1, 0, 1);
    step(1, 1, 32'h0, 0, 0, 0);
    step(1, 0, 32'h0, 0, 0, 0);

    // reset while a load is outstanding
    step(1, 0, 32'h8C450010, 1, 0, 0);
    step(0, 0, 32'h0, 0, 0, 0);
    mid_reset();
    step(0, 0, 32'hCAFEF00D, 0, 0, 0);
    step(1, 0, 32'h0000_0020, 0, 0, 0);

    // HALT carrying a store decode, then ignored activity
    step(1, 0, 32'hFFFFFFFF, 0, 1, 1);
    step(1, 1, 32'h0, 1, 0, 0);
    step(0, 1, 32'h0, 0, 0, 0);
    step(1, 0, 32'h0, 0, 0, 0);
    mid_reset();

    // randomized traffic
    for (int c = 0; c < 800; c++) begin
      if ((m_mode == 2 && $urandom_range(0, 3) == 0) ||
          (m_mode == 1 && $urandom_range(0, 24) == 0)) begin
        mid_reset();
      end else begin
        i  = ($urandom_range(0, 1) == 1);
        d  = ($urandom_range(0, 2) == 0);
        rr = ($urandom_range(0, 2) == 0);
        ww = ($urandom_range(0, 3) == 0);
        hh = ($urandom_range(0, 39) == 0);
        step(i, d, $urandom, rr, ww, hh);
      end
    end

    // retire counter wrap on the 4-bit instance
    @(negedge CLK);
    #2 nRST4 = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge CLK);
      bus4.ihit = 1'b1;
      #1;
      chk("wrap_count", 32'(bus4.retired), 32'(k));
      chk("wrap_pcen",  32'(bus4.pcen),    32'd1);
      @(posedge CLK);
    end
    @(negedge CLK);
    bus4.ihit = 1'b0;
    #1;
    chk("wrap_zero", 32'(bus4.retired), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
